seq_divider: RTL and testbench

- Multi-cycle signed two's-complement divider; the inverse operation of the team's combinational partial-product multiplier.
- Accepts a `bit_width_A`-bit dividend and a `bit_width_B`-bit divisor.
- Produces quotient and remainder by restoring division, one quotient bit per clock.
- Sits in the datapath wherever a product must be undone (scaling, normalisation), behind a valid/ready handshake on both sides.

---
 rtl/seq_divider.sv | 152 +++++++++++++++
 tb/tb_seq_divider.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, truncating
// toward zero, valid/ready on both the operand and the result side.
module seq_divider #(
  parameter int bit_width_A = 17,
  parameter int bit_width_B = 4,
  parameter int cnt_width   = $clog2(bit_width_A + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [bit_width_A-1:0] in_A,
  input  logic [bit_width_B-1:0] in_B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [bit_width_A-1:0] quotient,
  output logic [bit_width_B-1:0] remainder,
  output logic                   div_by_zero,
  output logic                   overflow,
  output logic [2:0]             dbg_state
);

  localparam int WA = bit_width_A;
  localparam int WB = bit_width_B;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and operands/results stay put
  // until that edge.
  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} state_t;

  state_t state, state_nxt;

  logic [WA-1:0]        a_reg;
  logic [WB-1:0]        b_reg;
  logic [WA-1:0]        quo_sh;
  logic [WA-1:0]        partial_rem;
  logic [WA:0]          mag_b;
  logic [cnt_width-1:0] cnt;
  logic                 sign_q;
  logic                 sign_r;

  logic [WA-1:0] mag_a;
  logic [WB-1:0] mag_b_small;
  logic [WA:0]   rem_shift;
  logic          q_bit;
  logic [WA-1:0] quo_fix;
  logic [WB-1:0] rem_fix;
  logic          is_zero;
  logic          is_ovf;

  assign dbg_state = state;

  // Magnitudes are unsigned, so the most negative operand maps to 2^(W-1)
  // without needing an extra bit.
  assign mag_a       = a_reg[WA-1] ? -a_reg : a_reg;
  assign mag_b_small = b_reg[WB-1] ? -b_reg : b_reg;

  assign rem_shift = {partial_rem, quo_sh[WA-1]};
  assign q_bit     = (rem_shift >= mag_b);

  assign quo_fix = sign_q ? -quo_sh : quo_sh;
  assign rem_fix = sign_r ? -partial_rem[WB-1:0] : partial_rem[WB-1:0];
  assign is_zero = (b_reg == '0);
  assign is_ovf  = (a_reg == {1'b1, {(WA-1){1'b0}}}) && (b_reg == '1);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SETUP;
      end
      SETUP: state_nxt = ITER;
      ITER:  if (cnt == '0) state_nxt = FIXUP;
      FIXUP: state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg       <= '0;
      b_reg       <= '0;
      quo_sh      <= '0;
      partial_rem <= '0;
      mag_b       <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_A;
            b_reg <= in_B;
          end
        end
        SETUP: begin
          quo_sh      <= mag_a;
          mag_b       <= {{(WA+1-WB){1'b0}}, mag_b_small};
          sign_q      <= a_reg[WA-1] ^ b_reg[WB-1];
          sign_r      <= a_reg[WA-1];
          partial_rem <= '0;
          cnt         <= cnt_width'(WA - 1);
        end
        ITER: begin
          // quo_sh doubles as the dividend shifter: its MSB feeds the partial
          // remainder while the new quotient bit enters at the LSB.
          quo_sh      <= {quo_sh[WA-2:0], q_bit};
          partial_rem <= WA'(q_bit ? rem_shift - mag_b : rem_shift);
          cnt         <= cnt - 1'b1;
        end
        FIXUP: begin
          if (is_zero) begin
            quotient    <= '1;
            remainder   <= a_reg[WB-1:0];
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (is_ovf) begin
            // Magnitude 2^(WA-1) reads back as the most negative value.
            quotient    <= quo_fix;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= quo_fix;
            remainder   <= rem_fix;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed sign/corner/backpressure/reset steps, then
// random operands against a truncating-division reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_A;
  logic [3:0]  in_B;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] quotient;
  logic [3:0]  remainder;
  logic        div_by_zero;
  logic        overflow;
  logic [2:0]  dbg_state;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  seq_divider #(.bit_width_A(17), .bit_width_B(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division truncates toward zero; special cases
  // come straight from the divide-by-zero and overflow rules.
  task automatic model(input int a, input int b, output logic [16:0] q,
                       output logic [3:0] r, output logic dz, output logic ov);
    int qi, ri;
    dz = 1'b0;
    ov = 1'b0;
    if (b == 0) begin
      q  = 17'h1FFFF;
      r  = a[3:0];
      dz = 1'b1;
    end else if (a == -65536 && b == -1) begin
      q  = 17'h10000;
      r  = 4'h0;
      ov = 1'b1;
    end else begin
      qi = a / b;
      ri = a % b;
      q  = qi[16:0];
      r  = ri[3:0];
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic start_op(input int a, input int b);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    in_A     = a[16:0];
    in_B     = b[3:0];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts accept-relative edges until out_valid, bounded.
  task automatic wait_result(output int lat);
    int k = 0;
    while (out_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) check("out_valid_timeout", 32'd0, 32'd1);
    lat = k;
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_model(input string tag, input int a, input int b);
    logic [16:0] q;
    logic [3:0]  r;
    logic        dz, ov;
    model(a, b, q, r, dz, ov);
    check({tag, "_q"}, quotient, q);
    check({tag, "_r"}, remainder, r);
    check({tag, "_dz"}, div_by_zero, dz);
    check({tag, "_ov"}, overflow, ov);
  endtask

  task automatic directed(input string tag, input int a, input int b, input logic [16:0] eq,
                          input logic [3:0] er, input logic edz, input logic eov);
    int lat;
    start_op(a, b);
    wait_result(lat);
    check({tag, "_lat"}, lat, 32'd19);
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, div_by_zero, edz);
    check({tag, "_ov"}, overflow, eov);
    finish_op();
  endtask

  initial begin
    int lat, a, b;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_A      = '0;
    in_B      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 32'd1);
    check("rst_out_valid", out_valid, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dz", div_by_zero, 32'd0);
    check("rst_ov", overflow, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    directed("p100_7",    100,    7,  17'd14,             4'd2,          1'b0, 1'b0);
    directed("m100_7",   -100,    7,  17'h1FFF2,          4'hE,          1'b0, 1'b0);
    directed("p100_m8",   100,   -8,  17'h1FFF4,          4'd4,          1'b0, 1'b0);
    directed("m100_m8",  -100,   -8,  17'd12,             4'hC,          1'b0, 1'b0);
    directed("div0",        5,    0,  17'h1FFFF,          4'd5,          1'b1, 1'b0);
    directed("ovf",    -65536,   -1,  17'h10000,          4'd0,          1'b0, 1'b1);
    directed("zero",        0,    3,  17'd0,              4'd0,          1'b0, 1'b0);

    // Backpressure with a request pulsed while busy.
    start_op(1000, 3);
    repeat (3) @(negedge clk);
    in_A     = 17'd7;
    in_B     = 4'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_in_ready", in_ready, 32'd0);
    wait_result(lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_q", quotient, 32'd333);
      check("hold_r", remainder, 32'd1);
      check("hold_valid", out_valid, 32'd1);
      check("hold_in_ready", in_ready, 32'd0);
    end

    // Result handshake with a new request already waiting.
    in_A      = 17'h1FF9C;
    in_B      = 4'h8;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("b2b_idle_valid", out_valid, 32'd0);
    check("b2b_idle_ready", in_ready, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b_accepted", in_ready, 32'd0);
    wait_result(lat);
    check("b2b_lat", lat, 32'd19);
    check("b2b_q", quotient, 32'd12);
    check("b2b_r", remainder, 32'hC);
    finish_op();

    // Reset in the middle of ITER.
    start_op(12345, 5);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_in_ready", in_ready, 32'd1);
    check("mid_rst_valid", out_valid, 32'd0);
    check("mid_rst_q", quotient, 32'd0);
    check("mid_rst_r", remainder, 32'd0);
    check("mid_rst_dz", div_by_zero, 32'd0);
    check("mid_rst_ov", overflow, 32'd0);
    directed("post_rst", 100, 7, 17'd14, 4'd2, 1'b0, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0: begin
          case ($urandom_range(0, 4))
            0: a = -65536;
            1: a = 65535;
            2: a = -1;
            3: a = 0;
            default: a = 1;
          endcase
        end
        default: a = int'($urandom_range(0, 131071)) - 65536;
      endcase
      case ($urandom_range(0, 3))
        0: begin
          case ($urandom_range(0, 3))
            0: b = -8;
            1: b = 7;
            2: b = 0;
            default: b = -1;
          endcase
        end
        default: b = int'($urandom_range(0, 15)) - 8;
      endcase
      start_op(a, b);
      wait_result(lat);
      check("rand_lat", lat, 32'd19);
      check_model("rand", a, b);
      finish_op();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
